cnn_conv_seq: RTL and testbench
===============================

# cnn_conv_seq

Control sequencer for the single-MAC convolution datapath. It accepts an activation map and a filter over a valid/ready stream and loads both into the datapath. It then steps the filter over every output window (multiply, accumulate, store) and streams the OS×OS results out under valid/ready backpressure. It drives the datapath's clear/load/increment strobes directly and keeps its own mirror counters, so it does not depend on datapath status flags.

## Interface
- AS, 6, activation side length
- FS, 3, filter side length
- STR, 1, window stride; verified at 1
- ZP, 0, zero padding
- OS, (AS+2*ZP-FS)/STR+1, output side length; derived, never overridden
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a job; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE is exited
- done  out  1  one-cycle pulse at job completion
- in_valid / in_ready  in / out  1 / 1  input word handshake; the word itself goes straight to the datapath
- out_valid / out_ready  out / in  1 / 1  result handshake; the result word is the datapath output register
- dp_clr, dp_rclr, dp_cclr, dp_sftrclr, dp_sftcclr  out  1 each  datapath clears
- dp_mull, dp_addl, dp_resultl, dp_outl, dp_l, dp_fl  out  1 each  datapath register loads
- dp_rl, dp_cl, dp_sftrl, dp_sftcl  out  1 each  datapath index increments

## Operation
- Mirror counters: r/c (0..max(AS,FS,OS)-1) and wr/wc (window 0..OS-1). They change only in the same cycle as the matching dp_* increment or clear.
- Every strobe is a registered-state decode: Moore, except where a handshake qualifies it.
- States and transitions:
  - IDLE: start → CLR.
  - CLR: dp_clr, dp_rclr, dp_cclr, dp_sftrclr, dp_sftcclr asserted; → LOAD_A.
  - LOAD_A: in_ready=1. Each accepted word asserts dp_l and advances c. When c=AS-1: dp_cclr plus dp_rl. On the last word (r=c=AS-1): dp_rclr plus dp_cclr, → LOAD_F.
  - LOAD_F: same pattern with dp_fl and the FS bound, → MUL.
  - MUL: dp_mull; → ADD.
  - ADD: dp_addl and tap advance (dp_cl, or dp_cclr plus dp_rl). On the last tap: dp_rclr plus dp_cclr, → STORE. Otherwise → MUL.
  - STORE: dp_resultl; → NEXT.
  - NEXT: dp_clr, then advance the window.
    - wc<OS-1: dp_sftcl.
    - else: dp_sftcclr, plus dp_sftrl if wr<OS-1.
    - After the last window: dp_sftrclr, → OUT_LD. Otherwise → MUL.
  - OUT_LD: dp_outl; → OUT_WAIT.
  - OUT_WAIT: out_valid=1. On out_ready, advance r/c over OS×OS. Last result: → DONE. Otherwise → OUT_LD.
  - DONE: done=1; → IDLE.
- start outside IDLE is ignored. A job cannot be aborted except by rst.
- in_valid is ignored outside the load states. out_valid never drops without out_ready.

## Timing
- Reset (async, any state): state=IDLE, all counters 0, every output 0. Reset mid-job discards the job; the next start reloads everything.
- start high in IDLE at cycle 0: CLR at cycle 1, busy=1 from cycle 1.
- Load costs AS²+FS² accepted words; stalls extend it cycle-for-cycle.
- Per window: 2·FS²+2 cycles (defaults: 20). The add register is updated at the end of the last ADD, so STORE writes the completed sum.
- Output: 2 cycles per result minimum; the result is stable for the whole OUT_WAIT.
- Defaults with no stalls: start to done = 1+36+9+320+32+1 = 399 cycles.
- A simultaneous counter wrap and handshake in one cycle issues clear and increment on different indices only; the same index never gets both.

## Structure
- Shared package cnn_pkg: state enum, OS derivation function, counter width constant.
- Sub-module cnn_idx2d: a row/column counter with bound input, inc, clr, and last flag. It is instantiated for tap/load/output indices (bound muxed by state) and for window indices.

## Test plan
- Defaults, a[i][j]=1, f all 1, no stalls → 16 results, each = 9; done at cycle 399; busy low afterwards.
- a[i][j]=6i+j, f = identity-center (f[1][1]=1) → out[r][c] = 6(r+1)+(c+1), in row-major order.
- in_valid toggling 1/0 during load → in_ready high only in LOAD_A/LOAD_F; exactly 45 dp_l+dp_fl pulses; same results as the first scenario.
- out_ready low for 5 cycles on result 7 → out_valid held; dp_outl not reissued; stream order preserved.
- rst asserted in the MUL of window 3 → all outputs 0 the same cycle; a new start plus a full reload gives correct results.
- start pulsed during NEXT and OUT_WAIT → ignored; exactly one done pulse.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: state encoding and geometry helpers shared by the convolution sequencer.
package cnn_pkg;
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_CLR      = 4'd1;
    localparam logic [3:0] S_LOAD_A   = 4'd2;
    localparam logic [3:0] S_LOAD_F   = 4'd3;
    localparam logic [3:0] S_MUL      = 4'd4;
    localparam logic [3:0] S_ADD      = 4'd5;
    localparam logic [3:0] S_STORE    = 4'd6;
    localparam logic [3:0] S_NEXT     = 4'd7;
    localparam logic [3:0] S_OUT_LD   = 4'd8;
    localparam logic [3:0] S_OUT_WAIT = 4'd9;
    localparam logic [3:0] S_DONE     = 4'd10;
    localparam int CW = 3;
    function automatic int os_f(int as, int fs, int str, int zp);
        return (as + 2 * zp - fs) / str + 1;
    endfunction
    function automatic int max3_f(int a, int b, int c);
        return a > b ? (a > c ? a : c) : (b > c ? b : c);
    endfunction
    function automatic int cw_f(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/cnn_conv_seq_if.sv
// cnn_conv_seq_if: job handshake, input/output streams and datapath strobes.
interface cnn_conv_seq_if;
    logic start, busy, done;
    logic in_valid, in_ready, out_valid, out_ready;
    logic dp_clr, dp_rclr, dp_cclr, dp_sftrclr, dp_sftcclr;
    logic dp_mull, dp_addl, dp_resultl, dp_outl, dp_l, dp_fl;
    logic dp_rl, dp_cl, dp_sftrl, dp_sftcl;
    modport master (
        output start, in_valid, out_ready,
        input  busy, done, in_ready, out_valid,
        input  dp_clr, dp_rclr, dp_cclr, dp_sftrclr, dp_sftcclr,
        input  dp_mull, dp_addl, dp_resultl, dp_outl, dp_l, dp_fl,
        input  dp_rl, dp_cl, dp_sftrl, dp_sftcl
    );
    modport slave (
        input  start, in_valid, out_ready,
        output busy, done, in_ready, out_valid,
        output dp_clr, dp_rclr, dp_cclr, dp_sftrclr, dp_sftcclr,
        output dp_mull, dp_addl, dp_resultl, dp_outl, dp_l, dp_fl,
        output dp_rl, dp_cl, dp_sftrl, dp_sftcl
    );
endinterface

// File: rtl/cnn_idx2d.sv
// cnn_idx2d: row-major 2-D index counter that wraps to 0,0 after the last element.
module cnn_idx2d
    import cnn_pkg::*;
#(
    parameter int W = CW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] bound_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic         last_c_o,
    output logic         last_o
);
    logic [W-1:0] r_q, r_d, c_q, c_d;
    assign last_c_o = c_q == bound_i - 1'b1;
    assign last_o   = last_c_o && r_q == bound_i - 1'b1;
    always_comb begin
        c_d = clr_i || (inc_i && last_c_o) ? '0 : inc_i ? c_q + 1'b1 : c_q;
        r_d = clr_i || (inc_i && last_o) ? '0 : inc_i && last_c_o ? r_q + 1'b1 : r_q;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_q <= '0;
            c_q <= '0;
        end else begin
            r_q <= r_d;
            c_q <= c_d;
        end
endmodule

// File: rtl/cnn_conv_seq.sv
// cnn_conv_seq: load, window-step and unload sequencer for the single-MAC convolution datapath.
module cnn_conv_seq
    import cnn_pkg::*;
#(
    parameter int AS  = 6,
    parameter int FS  = 3,
    parameter int STR = 1,
    parameter int ZP  = 0
) (
    input logic           clk,
    input logic           rst,
    cnn_conv_seq_if.slave bus
);
    localparam int OS = os_f(AS, FS, STR, ZP);
    localparam int W  = cw_f(max3_f(AS, FS, OS));
    logic [3:0]   state_q, state_d;
    logic [W-1:0] bound;
    logic         ld_hs, out_hs, t_inc, t_clr, t_lc, t_last, w_inc, w_lc, w_last;
    assign ld_hs  = (state_q == S_LOAD_A || state_q == S_LOAD_F) && bus.in_valid;
    assign out_hs = state_q == S_OUT_WAIT && bus.out_ready;
    assign t_inc  = ld_hs || state_q == S_ADD || out_hs;
    assign t_clr  = state_q == S_CLR;
    assign w_inc  = state_q == S_NEXT;
    assign bound  = state_q == S_LOAD_A ? W'(AS)
                  : state_q inside {S_OUT_LD, S_OUT_WAIT} ? W'(OS) : W'(FS);
    // One index pair serves load, tap and unload phases; the bound follows the phase.
    cnn_idx2d #(.W(W)) u_tap (
        .clk(clk), .rst(rst), .bound_i(bound), .inc_i(t_inc), .clr_i(t_clr),
        .last_c_o(t_lc), .last_o(t_last)
    );
    cnn_idx2d #(.W(W)) u_win (
        .clk(clk), .rst(rst), .bound_i(W'(OS)), .inc_i(w_inc), .clr_i(t_clr),
        .last_c_o(w_lc), .last_o(w_last)
    );
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = bus.start ? S_CLR : S_IDLE;
            S_CLR:      state_d = S_LOAD_A;
            S_LOAD_A:   state_d = ld_hs && t_last ? S_LOAD_F : S_LOAD_A;
            S_LOAD_F:   state_d = ld_hs && t_last ? S_MUL : S_LOAD_F;
            S_MUL:      state_d = S_ADD;
            S_ADD:      state_d = t_last ? S_STORE : S_MUL;
            S_STORE:    state_d = S_NEXT;
            S_NEXT:     state_d = w_last ? S_OUT_LD : S_MUL;
            S_OUT_LD:   state_d = S_OUT_WAIT;
            S_OUT_WAIT: state_d = out_hs ? (t_last ? S_DONE : S_OUT_LD) : S_OUT_WAIT;
            default:    state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    assign bus.busy       = state_q != S_IDLE;
    assign bus.done       = state_q == S_DONE;
    assign bus.in_ready   = state_q == S_LOAD_A || state_q == S_LOAD_F;
    assign bus.out_valid  = state_q == S_OUT_WAIT;
    assign bus.dp_l       = state_q == S_LOAD_A && bus.in_valid;
    assign bus.dp_fl      = state_q == S_LOAD_F && bus.in_valid;
    assign bus.dp_mull    = state_q == S_MUL;
    assign bus.dp_addl    = state_q == S_ADD;
    assign bus.dp_resultl = state_q == S_STORE;
    assign bus.dp_outl    = state_q == S_OUT_LD;
    assign bus.dp_clr     = t_clr || w_inc;
    assign bus.dp_cl      = t_inc && !t_lc;
    assign bus.dp_rl      = t_inc && t_lc && !t_last;
    assign bus.dp_cclr    = t_clr || (t_inc && t_lc);
    assign bus.dp_rclr    = t_clr || (t_inc && t_last);
    assign bus.dp_sftcl   = w_inc && !w_lc;
    assign bus.dp_sftrl   = w_inc && w_lc && !w_last;
    assign bus.dp_sftcclr = t_clr || (w_inc && w_lc);
    assign bus.dp_sftrclr = t_clr || (w_inc && w_last);
endmodule

// File: tb/tb_cnn_conv_seq.sv
// tb_cnn_conv_seq: drives jobs through the sequencer with a behavioural datapath and checks results and timing.
module tb_cnn_conv_seq;
    logic clk = 0;
    logic rst = 1;
    cnn_conv_seq_if bus();
    cnn_conv_seq dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    int nchk = 0, nfail = 0, cyc = 0;
    int A[6][6], F[3][3], ex[16];
    int da[6][6], df[3][3], res[4][4];
    int dr, dc, sr, sc, mul, acc, outr, in_data;
    int n_ld = 0, n_outl = 0, n_store = 0, n_done = 0, t_done = 0;
    int rcv = 0, rcv_base = 0, stall_left = 0, held = 0;
    bit stall_en = 0, holding = 0;
    int t0, ld0, outl0, done0;
    task automatic chk(input string nm, input int got, input int want);
        nchk++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endtask
    function automatic logic [18:0] outs();
        return {bus.busy, bus.done, bus.in_ready, bus.out_valid,
                bus.dp_clr, bus.dp_rclr, bus.dp_cclr, bus.dp_sftrclr, bus.dp_sftcclr,
                bus.dp_mull, bus.dp_addl, bus.dp_resultl, bus.dp_outl, bus.dp_l, bus.dp_fl,
                bus.dp_rl, bus.dp_cl, bus.dp_sftrl, bus.dp_sftcl};
    endfunction
    // Datapath stand-in: registers and index registers driven only by the strobes.
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or posedge rst)
        if (rst) begin
            dr <= 0; dc <= 0; sr <= 0; sc <= 0; acc <= 0;
        end else begin
            if (bus.dp_l) da[dr][dc] <= in_data;
            if (bus.dp_fl) df[dr][dc] <= in_data;
            if (bus.dp_l || bus.dp_fl) n_ld <= n_ld + 1;
            if (bus.dp_mull) mul <= da[sr+dr][sc+dc] * df[dr][dc];
            if (bus.dp_clr) acc <= 0;
            else if (bus.dp_addl) acc <= acc + mul;
            if (bus.dp_resultl) begin
                res[sr][sc] <= acc;
                n_store <= n_store + 1;
            end
            if (bus.dp_outl) begin
                outr <= res[dr][dc];
                n_outl <= n_outl + 1;
            end
            dr <= bus.dp_rclr ? 0 : bus.dp_rl ? dr + 1 : dr;
            dc <= bus.dp_cclr ? 0 : bus.dp_cl ? dc + 1 : dc;
            sr <= bus.dp_sftrclr ? 0 : bus.dp_sftrl ? sr + 1 : sr;
            sc <= bus.dp_sftcclr ? 0 : bus.dp_sftcl ? sc + 1 : sc;
        end
    initial begin
        bus.out_ready = 1;
        forever begin
            @(posedge clk); #1;
            if (stall_en && bus.out_valid && rcv - rcv_base == 6 && stall_left > 0) begin
                bus.out_ready = 0;
                stall_left--;
            end else bus.out_ready = 1;
        end
    end
    initial forever begin
        @(negedge clk);
        if (rst) holding = 0;
        else begin
            if (bus.done) begin
                n_done++;
                t_done = cyc;
            end
            if (bus.dp_l || bus.dp_fl) chk("load_handshake", int'(bus.in_valid && bus.in_ready), 1);
            if (bus.in_ready) chk("in_ready_phase", int'(bus.busy && !bus.out_valid && !bus.dp_mull && !bus.dp_addl && !bus.dp_outl), 1);
            if (bus.dp_rl || bus.dp_cl || bus.dp_sftrl || bus.dp_sftcl)
                chk("index_clash", int'({bus.dp_rclr & bus.dp_rl, bus.dp_cclr & bus.dp_cl,
                                        bus.dp_sftrclr & bus.dp_sftrl, bus.dp_sftcclr & bus.dp_sftcl}), 0);
            if (holding) begin
                chk("valid_hold", int'(bus.out_valid), 1);
                chk("result_hold", outr, held);
            end
            holding = 0;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    if (rcv - rcv_base < 16) chk($sformatf("result%0d", rcv - rcv_base), outr, ex[rcv - rcv_base]);
                    else chk("extra_result", rcv - rcv_base, 15);
                    rcv++;
                end else begin
                    holding = 1;
                    held = outr;
                end
            end
        end
    end
    task automatic set_ones();
        foreach (A[i, j]) A[i][j] = 1;
        foreach (F[i, j]) F[i][j] = 1;
    endtask
    task automatic set_ramp();
        foreach (A[i, j]) A[i][j] = 6 * i + j;
        foreach (F[i, j]) F[i][j] = (i == 1 && j == 1) ? 1 : 0;
    endtask
    task automatic model();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ex[r*4+c] = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++) ex[r*4+c] += A[r+i][c+j] * F[i][j];
            end
    endtask
    task automatic go();
        @(negedge clk);
        rcv_base = rcv; ld0 = n_ld; outl0 = n_outl; done0 = n_done;
        bus.start = 1;
        t0 = cyc;
        @(negedge clk);
        bus.start = 0;
    endtask
    task automatic feed(input bit toggle);
        int k = 0, g = 0;
        while (k < 45 && g < 500) begin
            bus.in_valid = toggle ? (g % 2 == 0) : 1'b1;
            in_data = k < 36 ? A[k/6][k%6] : F[(k-36)/3][(k-36)%3];
            if (bus.in_valid && bus.in_ready) k++;
            @(negedge clk);
            g++;
        end
        bus.in_valid = 0;
        chk("words_fed", k, 45);
    endtask
    task automatic finish_job(input int lat);
        int g = 0;
        while (n_done == done0 && g < 3000) begin
            @(negedge clk); #1;
            g++;
        end
        chk("done_seen", int'(n_done > done0), 1);
        if (lat > 0) chk("start_to_done", t_done - t0, lat);
        repeat (5) @(negedge clk);
        #1;
        chk("one_done", n_done - done0, 1);
        chk("busy_after", int'(bus.busy), 0);
        chk("load_pulses", n_ld - ld0, 45);
        chk("outl_pulses", n_outl - outl0, 16);
        chk("results_seen", rcv - rcv_base, 16);
    endtask
    task automatic wait_neg(input int sel);
        int g = 0;
        bit hit = 0;
        while (!hit && g < 2000) begin
            @(negedge clk); #1;
            g++;
            hit = sel == 0 ? (bus.dp_sftcl || bus.dp_sftcclr)
                : sel == 1 ? bus.out_valid : (n_store == 3 && bus.dp_mull);
        end
        chk($sformatf("wait_event%0d", sel), int'(hit), 1);
    endtask
    initial begin
        bus.start = 0; bus.in_valid = 0; in_data = 0;
        #1 chk("reset_outputs", int'(outs()), 0);
        #22;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("idle_outputs", int'(outs()), 0);
        set_ones(); model();
        chk("model_ones", ex[5], 9);
        go(); feed(0); finish_job(399);
        set_ramp(); model();
        chk("model_ramp_first", ex[0], 7);
        chk("model_ramp_last", ex[15], 28);
        go(); feed(0);
        wait_neg(0);
        bus.start = 1;
        @(negedge clk); bus.start = 0;
        wait_neg(1);
        bus.start = 1;
        @(negedge clk); bus.start = 0;
        finish_job(399);
        set_ones(); model();
        go(); feed(1); finish_job(0);
        set_ramp(); model();
        stall_en = 1; stall_left = 5;
        go(); feed(0); finish_job(404);
        stall_en = 0;
        n_store = 0;
        go(); feed(0);
        wait_neg(2);
        rst = 1;
        #1 chk("reset_midjob_outputs", int'(outs()), 0);
        @(negedge clk);
        rst = 0;
        set_ramp(); model();
        go(); feed(0); finish_job(399);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", nfail);
        $fatal(1);
    end
endmodule
